// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable wait states.
// Define AHB_SRAM_ERROR_EN to answer out-of-range, oversize and misaligned transfers with a two-cycle ERROR.
module ahb_lite_sram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  // Handshake: an address phase is taken at a posedge with HSEL, HREADY and
  // HTRANS[1] high; its data phase completes at the first posedge where
  // HREADYOUT is high, which is also where the next address phase is taken.

  state_e                 state_q;
  logic [2:0]             wait_cnt_q;
  logic                   ready_q;
  logic                   resp_q;
  logic                   write_q;
  logic [ADDR_BITS-1:0]   widx_q;
  logic [3:0]             strb_q;
  logic [3:0]             strb_d;
  logic [1:0]             size_eff;
  logic                   accept;
  logic                   go_err;
  logic                   unused_ok;

  logic [31:0] mem [DEPTH];

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign size_eff = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];

  // Little-endian lanes; larger sizes are aligned down to their natural boundary.
  always_comb begin
    strb_d = 4'b1111;
    case (size_eff)
      2'd0:    strb_d = 4'b0001 << HADDR[1:0];
      2'd1:    strb_d = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb_d = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERROR_EN
  assign go_err = ((HADDR >> (ADDR_BITS + 2)) != 32'd0) ||
                  (HSIZE > 3'd2) ||
                  ((HSIZE == 3'd1) && HADDR[0]) ||
                  ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign unused_ok = ^{HBURST, HTRANS[0]};
`else
  assign go_err    = 1'b0;
  assign unused_ok = ^{HBURST, HTRANS[0], HADDR[31:ADDR_BITS+2]};
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      write_q    <= 1'b0;
      widx_q     <= '0;
      strb_q     <= 4'b0000;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
`ifdef AHB_SRAM_ERROR_EN
        S_ERR1: begin
          state_q <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
`endif
        // IDLE, DATA and ERR2 all sit with HREADYOUT high and may take a new transfer.
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          if (accept) begin
            write_q <= HWRITE;
            widx_q  <= HADDR[ADDR_BITS+1:2];
            strb_q  <= strb_d;
            if (go_err) begin
              state_q <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
              write_q <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state_q    <= S_WAIT;
              ready_q    <= 1'b0;
              wait_cnt_q <= WAIT_INIT;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
      endcase
    end
  end

  // Memory is never cleared; a write is dropped if reset lands on its last cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[widx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA      = ((state_q == S_DATA) && !write_q) ? mem[widx_q] : 32'd0;
  assign HREADYOUT   = ready_q;
  assign HRESP       = resp_q;
  assign dbg_state_o = state_q;

endmodule
